ddram_arbiter: RTL and testbench



---
 rtl/ddram_arbiter_if.sv | 45 ++++
 rtl/ddram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ddram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddram_arbiter_if.sv
// Requester ports and DDRAM Avalon bus bundle for ddram_arbiter (slave = arbiter view).
interface ddram_arbiter_if #(parameter int unsigned AW = 25);
    logic          p0_req_i;
    logic [AW-1:0] p0_addr_i;
    logic [7:0]    p0_din_i;
    logic          p0_ack_o;
    logic          p1_req_i;
    logic          p1_we_i;
    logic [AW-1:0] p1_addr_i;
    logic [7:0]    p1_din_i;
    logic [7:0]    p1_dout_o;
    logic          p1_ack_o;
    logic          p2_req_i;
    logic [AW-1:0] p2_addr_i;
    logic [7:0]    p2_dout_o;
    logic          p2_ack_o;
    logic          busy_o;
    logic          DDRAM_BUSY;
    logic [7:0]    DDRAM_BURSTCNT;
    logic [28:0]   DDRAM_ADDR;
    logic [63:0]   DDRAM_DOUT;
    logic          DDRAM_DOUT_READY;
    logic          DDRAM_RD;
    logic [63:0]   DDRAM_DIN;
    logic [7:0]    DDRAM_BE;
    logic          DDRAM_WE;

    modport slave (
        input  p0_req_i, p0_addr_i, p0_din_i,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_din_i,
        input  p2_req_i, p2_addr_i,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output p0_ack_o, p1_dout_o, p1_ack_o, p2_dout_o, p2_ack_o, busy_o,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport master (
        output p0_req_i, p0_addr_i, p0_din_i,
        output p1_req_i, p1_we_i, p1_addr_i, p1_din_i,
        output p2_req_i, p2_addr_i,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  p0_ack_o, p1_dout_o, p1_ack_o, p2_dout_o, p2_ack_o, busy_o,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/ddram_arbiter.sv
// Round-robin arbiter sharing one 64-bit DDRAM port among loader, CPU and tape,
// with byte-lane packing and a one-line read cache for the tape port.
module ddram_arbiter #(
    parameter int unsigned AW        = 25,
    parameter logic [28:0] BASE_ADDR = 29'h06000000
) (
    input  logic           clk_i,
    input  logic           reset_i,
    output logic           DDRAM_CLK,
    ddram_arbiter_if.slave bus
);
    localparam int unsigned TW = AW - 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          is_wr_q, is_wr_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [63:0]   line_q, line_d;
    logic [2:0]    ack_q, ack_d;
    logic [7:0]    p1_dout_q, p1_dout_d;
    logic [7:0]    p2_dout_q, p2_dout_d;
    logic          busy_q, busy_d;
    logic          rd_q, rd_d;
    logic          we_q, we_d;
    logic [28:0]   ddr_addr_q, ddr_addr_d;
    logic [63:0]   din_q, din_d;
    logic [7:0]    be_q, be_d;

    logic [2:0]    pend;
    logic [1:0]    pick;
    logic [AW-1:0] sel_addr;
    logic [7:0]    sel_din;
    logic          sel_wr;
    logic [7:0]    rd_byte;

    // First pending port after 'last' in the rotation 0->1->2->0
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] p;
        rr_pick = last;
        for (int i = 3; i >= 1; i--) begin
            p = 2'((int'(last) + i) % 3);
            if (req[p]) rr_pick = p;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        line_d     = line_q;
        ack_d      = 3'b000;
        p1_dout_d  = p1_dout_q;
        p2_dout_d  = p2_dout_q;
        rd_d       = rd_q;
        we_d       = we_q;
        ddr_addr_d = ddr_addr_q;
        din_d      = din_q;
        be_d       = be_q;
        pend       = {bus.p2_req_i, bus.p1_req_i, bus.p0_req_i};
        pick       = rr_pick(last_q, pend);
        rd_byte    = bus.DDRAM_DOUT[{addr_q[2:0], 3'b000} +: 8];
        case (pick)
            2'd0:    begin sel_addr = bus.p0_addr_i; sel_din = bus.p0_din_i; sel_wr = 1'b1;          end
            2'd1:    begin sel_addr = bus.p1_addr_i; sel_din = bus.p1_din_i; sel_wr = bus.p1_we_i;   end
            default: begin sel_addr = bus.p2_addr_i; sel_din = 8'h00;        sel_wr = 1'b0;          end
        endcase

        case (state_q)
            IDLE: begin
                if (pend != 3'b000) begin
                    last_d  = pick;
                    gnt_d   = pick;
                    addr_d  = sel_addr;
                    is_wr_d = sel_wr;
                    if (pick == 2'd2 && valid_q && tag_q == bus.p2_addr_i[AW-1:3]) begin
                        p2_dout_d = line_q[{bus.p2_addr_i[2:0], 3'b000} +: 8];
                        ack_d[2]  = 1'b1;
                        state_d   = DONE;
                    end else begin
                        ddr_addr_d = BASE_ADDR + 29'(sel_addr[AW-1:3]);
                        if (sel_wr) begin
                            we_d  = 1'b1;
                            din_d = {8{sel_din}};
                            be_d  = 8'(1) << sel_addr[2:0];
                        end else begin
                            rd_d = 1'b1;
                            be_d = 8'hFF;
                        end
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.DDRAM_BUSY) begin
                    rd_d = 1'b0;
                    we_d = 1'b0;
                    if (is_wr_q) begin
                        // Keep the tape line coherent with loader/CPU writes
                        if (valid_q && tag_q == addr_q[AW-1:3]) valid_d = 1'b0;
                        ack_d[gnt_q] = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (bus.DDRAM_DOUT_READY) begin
                    if (gnt_q == 2'd2) begin
                        p2_dout_d = rd_byte;
                        line_d    = bus.DDRAM_DOUT;
                        tag_d     = addr_q[AW-1:3];
                        valid_d   = 1'b1;
                    end else begin
                        p1_dout_d = rd_byte;
                    end
                    ack_d[gnt_q] = 1'b1;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            last_q     <= 2'd2;
            gnt_q      <= 2'd0;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            line_q     <= '0;
            ack_q      <= 3'b000;
            p1_dout_q  <= 8'h00;
            p2_dout_q  <= 8'h00;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            ddr_addr_q <= '0;
            din_q      <= '0;
            be_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            ack_q      <= ack_d;
            p1_dout_q  <= p1_dout_d;
            p2_dout_q  <= p2_dout_d;
            busy_q     <= busy_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            ddr_addr_q <= ddr_addr_d;
            din_q      <= din_d;
            be_q       <= be_d;
        end
    end

    assign DDRAM_CLK          = clk_i;
    assign bus.DDRAM_BURSTCNT = 8'd1;
    assign bus.DDRAM_ADDR     = ddr_addr_q;
    assign bus.DDRAM_RD       = rd_q;
    assign bus.DDRAM_WE       = we_q;
    assign bus.DDRAM_DIN      = din_q;
    assign bus.DDRAM_BE       = be_q;
    assign bus.p0_ack_o       = ack_q[0];
    assign bus.p1_ack_o       = ack_q[1];
    assign bus.p2_ack_o       = ack_q[2];
    assign bus.p1_dout_o      = p1_dout_q;
    assign bus.p2_dout_o      = p2_dout_q;
    assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_ddram_arbiter.sv
// Directed bench for ddram_arbiter: DDRAM memory responder, transaction-level
// reference model checked every cycle, plus literal expectations from the test plan.
module tb_ddram_arbiter;
    localparam int unsigned AW   = 25;
    localparam logic [28:0] BASE = 29'h06000000;

    logic clk     = 1'b0;
    logic reset_i = 1'b1;
    logic rst_q   = 1'b0;
    logic ddram_clk;

    ddram_arbiter_if #(.AW(AW)) bus ();

    ddram_arbiter #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .DDRAM_CLK(ddram_clk),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= reset_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- DDRAM memory responder ----------------
    logic        busy_v = 1'b0, rdy_v = 1'b0, man_rdy = 1'b0;
    logic [63:0] dout_v = '0, man_dout = '0;
    bit          auto_rsp = 1'b1;
    int          rd_lat = 2;
    bit          rd_pend = 1'b0;
    int          rd_cnt;
    logic [63:0] rd_word;
    int          n_rd = 0;
    logic [63:0] dram [int unsigned];
    logic [7:0]  ref_mem [int unsigned];

    assign bus.DDRAM_BUSY       = busy_v;
    assign bus.DDRAM_DOUT_READY = rdy_v | man_rdy;
    assign bus.DDRAM_DOUT       = man_rdy ? man_dout : dout_v;

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'(a * 7 + 3) ^ 8'(a >> 8);
    endfunction

    function automatic logic [63:0] word_rd(input int unsigned w);
        logic [63:0] v;
        if (dram.exists(w)) return dram[w];
        for (int b = 0; b < 8; b++) v[8*b +: 8] = init_byte(w * 8 + b);
        return v;
    endfunction

    function automatic logic [7:0] ref_byte(input int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    initial forever begin
        int unsigned wa;
        logic [63:0] w;
        @(negedge clk);
        if (!reset_i && !busy_v) begin
            wa = 32'(bus.DDRAM_ADDR - BASE);
            if (bus.DDRAM_WE) begin
                w = word_rd(wa);
                for (int b = 0; b < 8; b++) if (bus.DDRAM_BE[b]) w[8*b +: 8] = bus.DDRAM_DIN[8*b +: 8];
                dram[wa] = w;
            end
            if (bus.DDRAM_RD) begin
                n_rd++;
                if (auto_rsp) begin rd_pend = 1'b1; rd_cnt = rd_lat; rd_word = word_rd(wa); end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rdy_v = 1'b0;
        if (rd_pend) begin
            if (rd_cnt == 0) begin dout_v = rd_word; rdy_v = 1'b1; rd_pend = 1'b0; end
            else rd_cnt--;
        end
    end

    // ---------------- transaction-level reference model ----------------
    int          m_last;
    bit          m_valid;
    int unsigned m_tag;
    logic [7:0]  m_p1, m_p2;
    bit          p_v = 1'b0, p_we, p_hit;
    int          p_port, p_age;
    int unsigned p_addr;
    logic [7:0]  p_data;
    int          ack_total = 0;

    initial begin
        logic [2:0] req, acks;
        m_last = 2; m_valid = 1'b0; m_tag = 0; m_p1 = 8'h00; m_p2 = 8'h00;
        forever begin
            @(negedge clk);
            acks = {bus.p2_ack_o, bus.p1_ack_o, bus.p0_ack_o};
            if (acks != 3'b000) ack_total++;
            if (rst_q) begin
                m_last = 2; m_valid = 1'b0; p_v = 1'b0; m_p1 = 8'h00; m_p2 = 8'h00;
                chk("rst_acks", 64'(acks), 0);
                chk("rst_rd_we", {bus.DDRAM_RD, bus.DDRAM_WE}, 0);
                chk("rst_addr", 64'(bus.DDRAM_ADDR), 0);
                chk("rst_din", bus.DDRAM_DIN, 0);
                chk("rst_be", 64'(bus.DDRAM_BE), 0);
                chk("rst_busy", 64'(bus.busy_o), 0);
            end else begin
                if (p_v) p_age++;
                if (bus.DDRAM_RD || bus.DDRAM_WE) begin
                    if (!p_v || p_hit) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_cmd: got RD=%0b WE=%0b, required none", bus.DDRAM_RD, bus.DDRAM_WE);
                    end else begin
                        chk("cmd_kind", {bus.DDRAM_RD, bus.DDRAM_WE}, p_we ? 2'b01 : 2'b10);
                        chk("cmd_addr", 64'(bus.DDRAM_ADDR), 64'(BASE + 29'(p_addr >> 3)));
                        chk("cmd_be", 64'(bus.DDRAM_BE), p_we ? 64'(8'(1) << p_addr[2:0]) : 64'hFF);
                        if (p_we) chk("cmd_din", bus.DDRAM_DIN, {8{p_data}});
                    end
                end
                if (acks != 3'b000) begin
                    if (!p_v) begin
                        n_cmp++; n_err++;
                        $display("FAIL spurious_ack: got %0b, required 000", acks);
                    end else begin
                        chk("ack_port", 64'(acks), 64'(3'b001 << p_port));
                        if (p_hit) chk("hit_latency", 64'(p_age), 1);
                        if (p_we) begin
                            ref_mem[p_addr] = p_data;
                            if (m_valid && m_tag == (p_addr >> 3)) m_valid = 1'b0;
                        end else if (p_port == 1) begin
                            m_p1 = ref_byte(p_addr);
                        end else begin
                            m_p2 = ref_byte(p_addr);
                            if (!p_hit) begin m_valid = 1'b1; m_tag = p_addr >> 3; end
                        end
                        p_v = 1'b0;
                    end
                end
                if (p_v && p_age > 200) begin
                    n_cmp++; n_err++;
                    $display("FAIL pending_timeout: got no ack after %0d cycles, required ack", p_age);
                    p_v = 1'b0;
                end
            end
            chk("p1_dout", 64'(bus.p1_dout_o), 64'(m_p1));
            chk("p2_dout", 64'(bus.p2_dout_o), 64'(m_p2));
            // Predict the grant the next edge makes when the arbiter is idle
            req = {bus.p2_req_i, bus.p1_req_i, bus.p0_req_i};
            if (!reset_i && !bus.busy_o && !p_v && req != 3'b000) begin
                for (int k = 3; k >= 1; k--) if (req[(m_last + k) % 3]) p_port = (m_last + k) % 3;
                m_last = p_port;
                case (p_port)
                    0: begin p_we = 1'b1; p_addr = 32'(bus.p0_addr_i); p_data = bus.p0_din_i; end
                    1: begin p_we = bus.p1_we_i; p_addr = 32'(bus.p1_addr_i); p_data = bus.p1_din_i; end
                    default: begin p_we = 1'b0; p_addr = 32'(bus.p2_addr_i); p_data = 8'h00; end
                endcase
                p_hit = (p_port == 2) && m_valid && (m_tag == (p_addr >> 3));
                p_v = 1'b1; p_age = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [28:0] c_addr;
    logic [7:0]  c_be;
    logic [63:0] c_din;
    int          iss_cnt, lat, rdy_at, ack_at;

    task automatic set_req(input int port, input bit on, input bit we, input logic [AW-1:0] a, input logic [7:0] d);
        case (port)
            0: begin bus.p0_req_i = on; bus.p0_addr_i = a; bus.p0_din_i = d; end
            1: begin bus.p1_req_i = on; bus.p1_we_i = we; bus.p1_addr_i = a; bus.p1_din_i = d; end
            default: begin bus.p2_req_i = on; bus.p2_addr_i = a; end
        endcase
    endtask

    task automatic xact(input int port, input bit we, input logic [AW-1:0] a, input logic [7:0] d, input int stall);
        bit got = 1'b0;
        logic ack;
        @(posedge clk); #1;
        set_req(port, 1'b1, we, a, d);
        busy_v = (stall > 0);
        iss_cnt = 0; rdy_at = -1; ack_at = -1;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk);
            if (bus.DDRAM_RD || bus.DDRAM_WE) begin
                iss_cnt++;
                if (iss_cnt == 1) begin c_addr = bus.DDRAM_ADDR; c_be = bus.DDRAM_BE; c_din = bus.DDRAM_DIN; end
                if (iss_cnt == stall + 1) #1 busy_v = 1'b0;
            end
            if (bus.DDRAM_DOUT_READY) rdy_at = i;
            ack = (port == 0) ? bus.p0_ack_o : (port == 1) ? bus.p1_ack_o : bus.p2_ack_o;
            if (ack) begin got = 1'b1; ack_at = i; lat = i; end
        end
        chk("xact_done", 64'(got), 1);
        @(posedge clk); #1;
        set_req(port, 1'b0, we, a, d);
        busy_v = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1; reset_i = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    initial begin
        int order [$];
        int hits, rd0, acks0, first;
        bit got;
        bus.p0_req_i = 0; bus.p0_addr_i = '0; bus.p0_din_i = '0;
        bus.p1_req_i = 0; bus.p1_we_i = 0; bus.p1_addr_i = '0; bus.p1_din_i = '0;
        bus.p2_req_i = 0; bus.p2_addr_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        chk("burstcnt", 64'(bus.DDRAM_BURSTCNT), 1);
        chk("reset_p1_dout", 64'(bus.p1_dout_o), 0);

        // p1 write then read of the same byte
        xact(1, 1'b1, 25'h0000013, 8'hA5, 0);
        chk("wr_addr", 64'(c_addr), 64'(29'h06000002));
        chk("wr_be", 64'(c_be), 64'h08);
        chk("wr_din", c_din, 64'hA5A5A5A5A5A5A5A5);
        xact(1, 1'b0, 25'h0000013, 8'h00, 0);
        chk("rd_p1_dout", 64'(bus.p1_dout_o), 64'hA5);
        chk("rd_ack_after_ready", 64'(ack_at - rdy_at), 1);

        // Round robin with all three held
        do_reset(2);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 25'h0000200, 8'h11);
        set_req(1, 1'b1, 1'b0, 25'h0000013, 8'h00);
        set_req(2, 1'b1, 1'b0, 25'h0000300, 8'h00);
        for (int i = 0; i < 400 && order.size() < 6; i++) begin
            @(negedge clk);
            if (bus.p0_ack_o) order.push_back(0);
            if (bus.p1_ack_o) order.push_back(1);
            if (bus.p2_ack_o) order.push_back(2);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0); set_req(2, 1'b0, 1'b0, '0, '0);
        chk("rr_count", 64'(order.size()), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i % 3));

        // BUSY stall during a p0 write
        xact(0, 1'b1, 25'h0000409, 8'h3C, 5);
        chk("stall_issue_cycles", 64'(iss_cnt), 6);
        chk("stall_be", 64'(c_be), 64'h02);

        // Tape cache: one line fill, seven hits
        rd0 = n_rd; hits = 0;
        for (int a = 'h100; a <= 'h107; a++) begin
            xact(2, 1'b0, AW'(a), 8'h00, 0);
            chk("tape_byte", 64'(bus.p2_dout_o), 64'(init_byte(a)));
            if (a != 'h100 && lat == 2) hits++;
        end
        chk("tape_ddram_reads", 64'(n_rd - rd0), 1);
        chk("tape_hits", 64'(hits), 7);
        xact(0, 1'b1, 25'h0000104, 8'h5C, 0);
        rd0 = n_rd;
        xact(2, 1'b0, 25'h0000104, 8'h00, 0);
        chk("tape_refetch", 64'(n_rd - rd0), 1);
        chk("tape_new_byte", 64'(bus.p2_dout_o), 64'h5C);

        // Reset while a p1 read waits for data
        auto_rsp = 1'b0;
        acks0 = ack_total;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 25'h0000013, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (bus.DDRAM_RD) got = 1'b1; end
        chk("mid_rd_issued", 64'(got), 1);
        @(posedge clk); #1;
        reset_i = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 man_dout = 64'hFFFF_FFFF_A5FF_FFFF; man_rdy = 1'b1;
        @(posedge clk); #1 man_rdy = 1'b0;
        repeat (3) @(posedge clk);
        chk("mid_rd_no_ack", 64'(ack_total - acks0), 0);
        chk("mid_rd_p1_dout", 64'(bus.p1_dout_o), 0);
        auto_rsp = 1'b1;
        #1;
        set_req(0, 1'b1, 1'b1, 25'h0000500, 8'h77);
        set_req(1, 1'b1, 1'b0, 25'h0000013, 8'h00);
        set_req(2, 1'b1, 1'b0, 25'h0000600, 8'h00);
        first = -1;
        for (int i = 0; i < 100 && first < 0; i++) begin
            @(negedge clk);
            if (bus.p0_ack_o) first = 0; else if (bus.p1_ack_o) first = 1; else if (bus.p2_ack_o) first = 2;
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0); set_req(2, 1'b0, 1'b0, '0, '0);
        chk("post_reset_first_grant", 64'(first), 0);
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish by %0t, required completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
